// File: rtl/tick_timer_arbiter.sv
// tick_timer_arbiter
//   One prescaled delay timer shared by four requesters. A requester is
//   granted the timer, its delay (in ticks) is counted down, and its done
//   line pulses for one cycle when the delay expires.
//
//   Build option: define RR_ARB_EN for round-robin arbitration; otherwise
//   fixed priority with req[0] highest.
//
// Ports
//   clk       system clock, posedge
//   rst_n     asynchronous active-low reset
//   req       level request per requester; drop to abort
//   dly_flat  per-requester delay in ticks, requester i at [i*CW +: CW]
//   grant     one-hot timer owner, 0 when idle
//   cur_id    index of current owner, 0 when idle
//   busy      timer owned
//   done      one-cycle pulse to the owner on expiry
//   tick      prescaler pulse, only while counting
module tick_timer_arbiter #(
  parameter int unsigned PRESCALE = 50_000_000,
  parameter int unsigned CW       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*CW-1:0] dly_flat,
  output logic [3:0]      grant,
  output logic [1:0]      cur_id,
  output logic            busy,
  output logic [3:0]      done,
  output logic            tick
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [31:0]   presc;
  logic [CW-1:0] cnt;
  logic [1:0]    win;
  logic [CW-1:0] dly_sel;

`ifdef RR_ARB_EN
  logic [1:0] rr_ptr;
  logic [1:0] idx;

  // Scan offsets from high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      idx = rr_ptr + 2'(i - 1);
      if (req[idx]) win = idx;
    end
  end
`else
  always_comb begin
    win = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (req[2'(i - 1)]) win = 2'(i - 1);
    end
  end
`endif

  assign dly_sel = dly_flat[32'(win)*CW +: CW];
  assign tick    = (state == RUN) && (presc == PRESCALE - 1);
  assign busy    = |grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      presc  <= '0;
      cnt    <= '0;
      grant  <= '0;
      cur_id <= '0;
      done   <= '0;
`ifdef RR_ARB_EN
      rr_ptr <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state  <= RUN;
            grant  <= 4'b0001 << win;
            cur_id <= win;
            cnt    <= dly_sel;
            presc  <= '0;
          end
        end
        RUN: begin
          // Abort is checked first so it wins over a same-edge expiry.
          if (!req[cur_id]) begin
            state  <= IDLE;
            grant  <= '0;
            cur_id <= '0;
            cnt    <= '0;
            presc  <= '0;
`ifdef RR_ARB_EN
            rr_ptr <= cur_id + 2'd1;
`endif
          end else if (cnt == '0) begin
            state <= DONE;
            done  <= grant;
            presc <= '0;
          end else begin
            presc <= tick ? '0 : presc + 32'd1;
            if (tick) cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          grant  <= '0;
          cur_id <= '0;
          done   <= '0;
`ifdef RR_ARB_EN
          rr_ptr <= cur_id + 2'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
